// File: rtl/mdr_ctrl.sv
// mdr_ctrl: memory data register with sized, aligned, sign/zero-extending
// reads and lane-replicated writes over a level-request / ack memory port.
module mdr_ctrl #(
    parameter int REG_SIZE = 32,
    parameter int TIMEOUT  = 15,
    localparam int NBYTES  = REG_SIZE / 8,
    localparam int OFFW    = $clog2(NBYTES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mdr_in,
    input  logic [REG_SIZE-1:0] bus_mux_out,
    input  logic                rd_start,
    input  logic                wr_start,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [OFFW-1:0]     addr_lo,
    input  logic [REG_SIZE-1:0] m_data_in,
    input  logic                m_ack,
    output logic                m_rd_req,
    output logic                m_wr_req,
    output logic [REG_SIZE-1:0] m_data_out,
    output logic [NBYTES-1:0]   m_byte_en,
    output logic [REG_SIZE-1:0] mdr_output,
    output logic                busy,
    output logic                done,
    output logic                err
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [1:0] sz_q, sz_n;
    logic sx_q, sx_n;
    logic [OFFW-1:0] off_q, off_n;
    logic [REG_SIZE-1:0] mdr_n, wdata_n, rd_ext, wr_rep, shifted;
    logic [NBYTES-1:0] be_n, be_calc;
    logic rd_n, wr_n, done_n, err_n, misaligned;
    int nbits;
    // Write lanes and enables come from the live inputs: they are captured on the start edge.
    always_comb begin
        wr_rep = '0;
        be_calc = '0;
        for (int i = 0; i < NBYTES; i++) begin
            wr_rep[8*i +: 8] = mdr_output[8*(i & ((1 << size) - 1)) +: 8];
            be_calc[i] = (i >= int'(addr_lo)) && (i < int'(addr_lo) + (1 << size));
        end
    end
    // Read extraction uses the latched access so the result matches the issued request.
    always_comb begin
        shifted = m_data_in >> {off_q, 3'b000};
        nbits = ((8 << sz_q) > REG_SIZE) ? REG_SIZE : (8 << sz_q);
        rd_ext = '0;
        for (int j = 0; j < REG_SIZE; j++)
            rd_ext[j] = (j < nbits) ? shifted[j] : (sx_q & shifted[nbits-1]);
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sz_n = sz_q;
        sx_n = sx_q;
        off_n = off_q;
        mdr_n = mdr_output;
        wdata_n = m_data_out;
        be_n = m_byte_en;
        rd_n = m_rd_req;
        wr_n = m_wr_req;
        done_n = 1'b0;
        err_n = 1'b0;
        misaligned = (size == 2'd3 && REG_SIZE == 32) ||
                     ((32'(addr_lo) & ((32'd1 << size) - 32'd1)) != 32'd0);
        if (state == IDLE) begin
            if (rd_start || wr_start) begin
                sz_n = size;
                sx_n = sign_ext;
                off_n = addr_lo;
                cnt_n = 8'd0;
                if (misaligned) begin
                    err_n = 1'b1;
                end else if (rd_start) begin
                    state_n = RD_WAIT;
                    rd_n = 1'b1;
                end else begin
                    state_n = WR_WAIT;
                    wr_n = 1'b1;
                    wdata_n = wr_rep;
                    be_n = be_calc;
                end
            end else if (mdr_in) begin
                mdr_n = bus_mux_out;
            end
        end else if (m_ack || cnt == 8'(TIMEOUT - 1)) begin
            state_n = IDLE;
            cnt_n = 8'd0;
            rd_n = 1'b0;
            wr_n = 1'b0;
            wdata_n = '0;
            be_n = '0;
            done_n = m_ack;
            err_n = !m_ack;
            mdr_n = (m_ack && state == RD_WAIT) ? rd_ext : mdr_output;
        end else begin
            cnt_n = cnt + 8'd1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 8'd0;
            sz_q <= 2'd0;
            sx_q <= 1'b0;
            off_q <= '0;
            mdr_output <= '0;
            m_data_out <= '0;
            m_byte_en <= '0;
            m_rd_req <= 1'b0;
            m_wr_req <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            sz_q <= sz_n;
            sx_q <= sx_n;
            off_q <= off_n;
            mdr_output <= mdr_n;
            m_data_out <= wdata_n;
            m_byte_en <= be_n;
            m_rd_req <= rd_n;
            m_wr_req <= wr_n;
            busy <= (state_n != IDLE);
            done <= done_n;
            err <= err_n;
        end
    end
endmodule

// File: tb/tb_mdr_ctrl.sv
// tb_mdr_ctrl: directed checks of a 32-bit (TIMEOUT=4) and a 64-bit mdr_ctrl.
module tb_mdr_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mdr_in = 0, rd_start = 0, wr_start = 0, sign_ext = 0, m_ack = 0;
    logic [1:0] size = 0;
    logic [1:0] addr_lo = 0;
    logic [31:0] bus_mux_out = 0, m_data_in = 0;
    logic m_rd_req, m_wr_req, busy, done, err;
    logic [31:0] m_data_out, mdr_output;
    logic [3:0] m_byte_en;
    logic d_mdr_in = 0, d_rd_start = 0, d_wr_start = 0, d_sign_ext = 0, d_ack = 0;
    logic [1:0] d_size = 0;
    logic [2:0] d_addr_lo = 0;
    logic [63:0] d_bus = 0, d_data_in = 0;
    logic d_rd_req, d_wr_req, d_busy, d_done, d_err;
    logic [63:0] d_data_out, d_mdr;
    logic [7:0] d_byte_en;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    mdr_ctrl #(.TIMEOUT(4)) u32 (
        .clk(clk), .reset(reset), .mdr_in(mdr_in), .bus_mux_out(bus_mux_out),
        .rd_start(rd_start), .wr_start(wr_start), .size(size), .sign_ext(sign_ext),
        .addr_lo(addr_lo), .m_data_in(m_data_in), .m_ack(m_ack), .m_rd_req(m_rd_req),
        .m_wr_req(m_wr_req), .m_data_out(m_data_out), .m_byte_en(m_byte_en),
        .mdr_output(mdr_output), .busy(busy), .done(done), .err(err)
    );
    mdr_ctrl #(.REG_SIZE(64)) u64 (
        .clk(clk), .reset(reset), .mdr_in(d_mdr_in), .bus_mux_out(d_bus),
        .rd_start(d_rd_start), .wr_start(d_wr_start), .size(d_size), .sign_ext(d_sign_ext),
        .addr_lo(d_addr_lo), .m_data_in(d_data_in), .m_ack(d_ack), .m_rd_req(d_rd_req),
        .m_wr_req(d_wr_req), .m_data_out(d_data_out), .m_byte_en(d_byte_en),
        .mdr_output(d_mdr), .busy(d_busy), .done(d_done), .err(d_err)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        repeat (2) step();
        chk("rst_out", {mdr_output, m_data_out}, 64'h0);
        chk("rst_ctl", {m_rd_req, m_wr_req, m_byte_en, busy, done, err}, 9'h0);
        chk("rst_64", {d_mdr, d_rd_req, d_busy}, 66'h0);
        reset = 0;
        mdr_in = 1; bus_mux_out = 32'h11223344;
        step();
        mdr_in = 0;
        chk("load", mdr_output, 32'h11223344);
        chk("load_done", done, 0);
        rd_start = 1; size = 0; sign_ext = 1; addr_lo = 2; m_data_in = 32'hAA80CCDD;
        step();
        rd_start = 0; size = 2; sign_ext = 0; addr_lo = 0;
        chk("rd_req", {m_rd_req, m_wr_req, busy}, 3'b101);
        step();
        step();
        chk("rd_hold", {m_rd_req, mdr_output}, {1'b1, 32'h11223344});
        m_ack = 1;
        step();
        m_ack = 0;
        chk("rd_byte_sx", mdr_output, 32'hFFFFFF80);
        chk("rd_done", {done, err, m_rd_req, busy}, 4'b1000);
        step();
        chk("done_pulse", done, 0);
        m_ack = 1;
        step();
        m_ack = 0;
        chk("ack_idle", {done, mdr_output}, {1'b0, 32'hFFFFFF80});
        rd_start = 1; size = 1; sign_ext = 0; addr_lo = 2; m_data_in = 32'h87654321;
        step();
        rd_start = 0; m_ack = 1;
        step();
        m_ack = 0;
        chk("rd_half_zx", mdr_output, 32'h00008765);
        rd_start = 1; size = 1; sign_ext = 1; addr_lo = 0; m_data_in = 32'h1234F00D;
        step();
        rd_start = 0; m_ack = 1;
        step();
        m_ack = 0;
        chk("rd_half_sx", mdr_output, 32'hFFFFF00D);
        mdr_in = 1; bus_mux_out = 32'h0000BEEF;
        step();
        mdr_in = 0;
        wr_start = 1; size = 1; addr_lo = 2;
        step();
        wr_start = 0; mdr_in = 1; bus_mux_out = 32'h0;
        chk("wr_data", m_data_out, 32'hBEEFBEEF);
        chk("wr_be", {m_wr_req, m_rd_req, m_byte_en}, 6'b10_1100);
        step();
        mdr_in = 0;
        chk("wr_hold", {m_data_out, m_byte_en, mdr_output}, {32'hBEEFBEEF, 4'b1100, 32'h0000BEEF});
        m_ack = 1;
        step();
        m_ack = 0;
        chk("wr_done", {done, m_wr_req, busy, m_byte_en, m_data_out}, {3'b100, 4'b0, 32'h0});
        chk("wr_mdr", mdr_output, 32'h0000BEEF);
        wr_start = 1; size = 0; addr_lo = 1;
        step();
        wr_start = 0;
        chk("wr_byte", {m_data_out, m_byte_en}, {32'hEFEFEFEF, 4'b0010});
        m_ack = 1;
        step();
        m_ack = 0;
        rd_start = 1; size = 2; addr_lo = 1;
        step();
        rd_start = 0;
        chk("mis_err", {err, m_rd_req, busy}, 3'b100);
        step();
        chk("mis_clr", {err, m_rd_req, busy, mdr_output}, {3'b000, 32'h0000BEEF});
        rd_start = 1; size = 3; addr_lo = 0;
        step();
        rd_start = 0;
        chk("mis_dword32", {err, m_rd_req, busy}, 3'b100);
        rd_start = 1; size = 2; addr_lo = 0; m_data_in = 32'h5A5A5A5A;
        step();
        rd_start = 0;
        chk("to_c1", m_rd_req, 1);
        step();
        chk("to_c2", m_rd_req, 1);
        step();
        chk("to_c3", m_rd_req, 1);
        step();
        chk("to_c4", {m_rd_req, err}, 2'b10);
        step();
        chk("to_exit", {m_rd_req, err, busy, done}, 4'b0100);
        chk("to_mdr", mdr_output, 32'h0000BEEF);
        step();
        chk("to_err_pulse", err, 0);
        rd_start = 1; wr_start = 1; size = 2; addr_lo = 0;
        step();
        rd_start = 0; wr_start = 0;
        chk("prio", {m_rd_req, m_wr_req}, 2'b10);
        #2 reset = 1;
        #1;
        chk("async_rst", {m_rd_req, busy, mdr_output}, 34'h0);
        step();
        chk("rst_no_pulse", {done, err}, 2'b00);
        reset = 0;
        d_rd_start = 1; d_size = 3; d_addr_lo = 0; d_data_in = 64'h0123456789ABCDEF;
        step();
        d_rd_start = 0;
        chk("d_req", {d_rd_req, d_busy}, 2'b11);
        d_ack = 1;
        step();
        d_ack = 0;
        chk("d_dword", {d_done, d_mdr}, {1'b1, 64'h0123456789ABCDEF});
        d_rd_start = 1; d_size = 2; d_sign_ext = 1; d_addr_lo = 4;
        step();
        d_rd_start = 0; d_ack = 1;
        step();
        d_ack = 0;
        chk("d_word_sx", d_mdr, 64'h0000000001234567);
        d_mdr_in = 1; d_bus = 64'h00000000CAFEF00D;
        step();
        d_mdr_in = 0; d_wr_start = 1; d_size = 2; d_addr_lo = 4;
        step();
        d_wr_start = 0;
        chk("d_wr", {d_data_out, d_byte_en}, {64'hCAFEF00DCAFEF00D, 8'hF0});
        d_ack = 1;
        step();
        d_ack = 0;
        chk("d_wr_done", {d_done, d_wr_req, d_byte_en}, {2'b10, 8'h0});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdr_ctrl.md
MDR_CTRL -- requirements
Module: mdr_ctrl

Interface
REQ-001 SHALL have parameter REG_SIZE, default 32, data width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum wait cycles for m_ack; legal range 1..255.
REQ-003 SHALL derive NBYTES = REG_SIZE/8 and OFFW = log2(NBYTES) internally.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port mdr_in  input  1  load mdr_output from bus_mux_out.
REQ-007 SHALL have port bus_mux_out  input  REG_SIZE  internal bus data.
REQ-008 SHALL have port rd_start  input  1  begin memory read into MDR.
REQ-009 SHALL have port wr_start  input  1  begin memory write from MDR.
REQ-010 SHALL have port size  input  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-011 SHALL have port sign_ext  input  1  1 = sign-extend reads, 0 = zero-extend.
REQ-012 SHALL have port addr_lo  input  OFFW  byte offset of access within the word.
REQ-013 SHALL have port m_data_in  input  REG_SIZE  memory read data.
REQ-014 SHALL have port m_ack  input  1  memory completion strobe.
REQ-015 SHALL have port m_rd_req  output  1  memory read request, level.
REQ-016 SHALL have port m_wr_req  output  1  memory write request, level.
REQ-017 SHALL have port m_data_out  output  REG_SIZE  lane-replicated write data.
REQ-018 SHALL have port m_byte_en  output  NBYTES  write byte enables.
REQ-019 SHALL have port mdr_output  output  REG_SIZE  MDR contents.
REQ-020 SHALL have port busy  output  1  high when state is not IDLE.
REQ-021 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-022 SHALL have port err  output  1  one-cycle pulse on misalignment or timeout.

Function
REQ-023 SHALL implement states IDLE, RD_WAIT, WR_WAIT; all outputs registered.
REQ-024 In IDLE, priority SHALL be rd_start > wr_start > mdr_in; lower-priority inputs in the same cycle are dropped.
REQ-025 In IDLE, mdr_in alone SHALL load bus_mux_out into mdr_output at the next edge; no done pulse.
REQ-026 On start, size, sign_ext and addr_lo SHALL be latched, and the latched values used for the whole transaction.
REQ-027 An access SHALL be misaligned if addr_lo is not a multiple of its byte count, or if size=3 with REG_SIZE=32.
REQ-028 On a misaligned access: err=1 next cycle, state stays IDLE, no request issued, mdr_output unchanged.
REQ-029 On an aligned rd_start: next edge enters RD_WAIT with m_rd_req=1.
REQ-030 On an aligned wr_start: next edge enters WR_WAIT with m_wr_req=1.
REQ-031 In WR_WAIT, m_data_out SHALL be the low access bytes of mdr_output replicated across all lanes.
REQ-032 In WR_WAIT, m_byte_en SHALL have bits addr_lo..addr_lo+bytes-1 set; both outputs held stable until exit.
REQ-033 In RD_WAIT with m_ack=1, the edge SHALL load mdr_output with m_data_in bytes starting at addr_lo, extended per sign_ext to REG_SIZE.
REQ-034 In WR_WAIT with m_ack=1, the edge SHALL leave mdr_output unchanged.
REQ-035 On m_ack in either wait state, the same edge SHALL return to IDLE, drop the request, and assert done for one cycle.
REQ-036 A wait counter SHALL clear on entry to a wait state and increment each wait cycle without m_ack.
REQ-037 After TIMEOUT wait cycles without m_ack: return to IDLE, drop the request, err=1 for one cycle, mdr_output unchanged.
REQ-038 m_ack SHALL be ignored in IDLE; rd_start, wr_start and mdr_in SHALL be ignored while busy.
REQ-039 m_byte_en and m_data_out SHALL be zero outside WR_WAIT.

Reset
REQ-040 Reset SHALL immediately force state IDLE, wait counter 0, and all outputs (mdr_output, m_rd_req, m_wr_req, m_data_out, m_byte_en, busy, done, err) to 0.
REQ-041 Reset asserted mid-transaction SHALL drop the request asynchronously with no done or err pulse.

Verification
REQ-042 Load then byte read: mdr_in with bus 0x11223344, then rd_start size=0 sign_ext=1 addr_lo=2, m_data_in=0xAA80CCDD, ack 3 cycles later -> mdr_output=0xFFFFFF80, done one cycle.
REQ-043 Halfword write: mdr_output=0x0000BEEF, wr_start size=1 addr_lo=2 -> m_data_out=0xBEEFBEEF, m_byte_en=4'b1100, until ack, then done.
REQ-044 Misaligned access: rd_start size=2 addr_lo=1 -> err one cycle, m_rd_req never high, busy stays 0.
REQ-045 Timeout: TIMEOUT=4, rd_start with no ack -> m_rd_req high exactly 4 cycles, then err, mdr_output unchanged.
REQ-046 Reset and priority: rd_start and wr_start together -> m_rd_req only; reset asserted in RD_WAIT -> all outputs 0 immediately, no done pulse.
REQ-047 Dword read: REG_SIZE=64, size=3 addr_lo=0 -> full 64-bit m_data_in loaded into mdr_output.
